// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/ack access per op, byte-lane steering, load extension, timeout.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning the lane down.
module mem_stage_lsu #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [63:0]       i_mr,
  input  logic [63:0]       i_mqb,
  input  logic              i_mwmem,
  input  logic              i_mm2reg,
  input  logic [2:0]        i_mfunc3,
  output logic [63:0]       o_mmo,
  output logic              o_mstall,
  output logic              o_mbuserr,
  output logic              o_mmisalign,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-4:0] o_mem_addr,
  output logic [63:0]       o_mem_wdata,
  output logic [7:0]        o_mem_wstrb,
  input  logic              i_mem_ack,
  input  logic [63:0]       i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [15:0] LastCnt = 16'(TIMEOUT_CYC - 1);

  state_e            r_state, w_state_next;
  logic [15:0]       r_cnt;
  logic              r_req, r_we, r_is_load, r_buserr;
  logic [ADDR_W-4:0] r_addr;
  logic [63:0]       r_wdata, r_mmo;
  logic [7:0]        r_wstrb;
  logic [2:0]        r_func3, r_lane;

  logic        w_is_store, w_is_load, w_acc, w_trap, w_start, w_timeout;
  logic [2:0]  w_align_mask, w_lane;
  logic [7:0]  w_wstrb_base;
  logic [63:0] w_d, w_load_data;
  logic        w_unused_mr;

  // A store wins when both requests are raised.
  assign w_is_store   = i_mwmem;
  assign w_is_load    = i_mm2reg & ~i_mwmem;
  assign w_acc        = (w_is_store & ~i_mfunc3[2]) | (w_is_load & (i_mfunc3 != 3'b111));
  assign w_align_mask = 3'b111 << i_mfunc3[1:0];
  assign w_lane       = i_mr[2:0] & w_align_mask;
  assign w_unused_mr  = ^i_mr[63:ADDR_W];

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = |(i_mr[2:0] & ~w_align_mask);
  assign w_trap     = w_acc & w_misalign;
`else
  assign w_trap     = 1'b0;
`endif

  assign w_start     = w_acc & ~w_trap;
  assign o_mmisalign = w_trap & (r_state == StIdle) & ~i_rst;
  assign w_timeout   = (r_cnt == LastCnt);

  always_comb begin
    w_wstrb_base = 8'h00;
    unique case (i_mfunc3[1:0])
      2'd0: w_wstrb_base = 8'h01;
      2'd1: w_wstrb_base = 8'h03;
      2'd2: w_wstrb_base = 8'h0F;
      2'd3: w_wstrb_base = 8'hFF;
      default: w_wstrb_base = 8'h00;
    endcase
  end

  assign w_d = i_mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load_data = w_d;
    unique case (r_func3)
      3'b000: w_load_data = {{56{w_d[7]}}, w_d[7:0]};
      3'b001: w_load_data = {{48{w_d[15]}}, w_d[15:0]};
      3'b010: w_load_data = {{32{w_d[31]}}, w_d[31:0]};
      3'b100: w_load_data = {56'd0, w_d[7:0]};
      3'b101: w_load_data = {48'd0, w_d[15:0]};
      3'b110: w_load_data = {32'd0, w_d[31:0]};
      default: w_load_data = w_d;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    o_mstall     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = StBusy;
          o_mstall     = 1'b1;
        end
      end
      StBusy: begin
        o_mstall = 1'b1;
        if (i_mem_ack || w_timeout) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_is_load <= 1'b0;
      r_buserr  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_mmo     <= '0;
      r_func3   <= '0;
      r_lane    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_buserr <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_req     <= 1'b1;
            r_we      <= w_is_store;
            r_is_load <= w_is_load;
            r_addr    <= i_mr[ADDR_W-1:3];
            // Loads leave write data and strobes at zero.
            r_wdata   <= w_is_store ? (i_mqb << {w_lane, 3'b000}) : '0;
            r_wstrb   <= w_is_store ? (w_wstrb_base << w_lane) : '0;
            r_func3   <= i_mfunc3;
            r_lane    <= w_lane;
            r_cnt     <= '0;
          end
          if (w_trap) r_mmo <= '0;
        end
        StBusy: begin
          r_cnt <= r_cnt + 16'd1;
          if (i_mem_ack) begin
            r_req <= 1'b0;
            if (r_is_load) r_mmo <= w_load_data;
          end else if (w_timeout) begin
            r_req    <= 1'b0;
            r_buserr <= 1'b1;
            r_mmo    <= '0;
          end
        end
        StDone:  r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_mmo       = r_mmo;
  assign o_mbuserr   = r_buserr;
  assign o_mem_req   = r_req;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: transaction-level model drives per-cycle expectations, checked on negedge.
module tb_mem_stage_lsu;
  localparam int unsigned AW = 16;
  localparam int unsigned TO = 255;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] mr, mqb, mmo, mem_wdata, mem_rdata;
  logic        mwmem, mm2reg, mstall, mbuserr, mmisalign, mem_req, mem_we, mem_ack;
  logic [2:0]  mfunc3;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wstrb;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_mr(mr), .i_mqb(mqb), .i_mwmem(mwmem), .i_mm2reg(mm2reg),
    .i_mfunc3(mfunc3), .o_mmo(mmo), .o_mstall(mstall), .o_mbuserr(mbuserr),
    .o_mmisalign(mmisalign), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb), .i_mem_ack(mem_ack),
    .i_mem_rdata(mem_rdata)
  );

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int stall_cnt = 0, req_cnt = 0, buserr_cnt = 0, mis_cnt = 0;
  logic [12:0] last_addr;
  logic [63:0] last_wdata;
  logic [7:0]  last_wstrb;

  logic        e_stall = 0, e_req = 0, e_we = 0, e_buserr = 0, e_mis = 0;
  logic [12:0] e_addr = 0;
  logic [63:0] e_wdata = 0, e_mmo = 0;
  logic [7:0]  e_wstrb = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rules, written per byte.
  function automatic int sz_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int lane_of(input logic [63:0] a, input logic [2:0] f3);
    return (int'(a[2:0]) / sz_of(f3)) * sz_of(f3);
  endfunction

  function automatic bit legal_of(input logic we, input logic rd, input logic [2:0] f3);
    if (we) return f3 < 3'd4;
    if (rd) return f3 != 3'd7;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_wstrb(input logic [63:0] a, input logic [2:0] f3);
    logic [7:0] s = '0;
    for (int i = 0; i < sz_of(f3); i++) s[lane_of(a, f3) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] a, input logic [2:0] f3,
                                          input logic [63:0] d);
    logic [63:0] w = '0;
    int ln = lane_of(a, f3);
    for (int i = 0; i + ln < 8; i++) w[8*(ln+i) +: 8] = d[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] a, input logic [2:0] f3,
                                         input logic [63:0] rd);
    logic [63:0] v = '0;
    int ln = lane_of(a, f3);
    int sz = sz_of(f3);
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(ln+i) +: 8];
    if (f3 < 3'd3 && v[8*sz-1]) for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mstall", 64'(mstall), 64'(e_stall));
      chk("mem_req", 64'(mem_req), 64'(e_req));
      chk("mmo", mmo, e_mmo);
      chk("mbuserr", 64'(mbuserr), 64'(e_buserr));
      chk("mmisalign", 64'(mmisalign), 64'(e_mis));
      if (e_req) begin
        chk("mem_we", 64'(mem_we), 64'(e_we));
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_wstrb", 64'(mem_wstrb), 64'(e_wstrb));
      end
      if (mstall) stall_cnt++;
      if (mbuserr) buserr_cnt++;
      if (mmisalign) mis_cnt++;
      if (mem_req) begin
        req_cnt++;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
        last_wstrb = mem_wstrb;
      end
    end
  end

  task automatic drive_nop();
    mwmem = 0; mm2reg = 0; mfunc3 = 0; mr = 0; mqb = 0;
  endtask

  // ack_at: BUSY cycle (1-based) carrying mem_ack; 0 means the bus never answers.
  task automatic run_op(input logic we, input logic rd, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] d, input logic [63:0] rdata,
                        input int ack_at);
    bit legal = legal_of(we, rd, f3);
    bit mis = TRAP && legal && (int'(a[2:0]) % sz_of(f3) != 0);
    bit tmo = (ack_at == 0);
    int nbusy = tmo ? int'(TO) : ack_at;
    @(posedge clk); #1;
    mwmem = we; mm2reg = rd; mfunc3 = f3; mr = a; mqb = d; mem_ack = 0;
    e_req = 0; e_buserr = 0; e_mis = mis; e_stall = legal && !mis;
    if (!legal || mis) begin
      @(posedge clk); #1;
      drive_nop(); e_mis = 0; e_stall = 0;
      if (mis) e_mmo = '0;
      return;
    end
    for (int c = 1; c <= nbusy; c++) begin
      @(posedge clk); #1;
      e_stall = 1; e_req = 1; e_we = we; e_addr = a[15:3];
      e_wdata = we ? m_wdata(a, f3, d) : '0;
      e_wstrb = we ? m_wstrb(a, f3) : '0;
      mem_ack = (c == ack_at);
      mem_rdata = (c == ack_at) ? rdata : 64'hFFFF_FFFF_FFFF_FFFF;
    end
    @(posedge clk); #1;
    // A stray ack in the completion cycle must not start another access.
    mem_ack = 1; mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    e_stall = 0; e_req = 0; e_buserr = tmo;
    if (tmo) e_mmo = '0;
    else if (!we) e_mmo = m_load(a, f3, rdata);
    @(posedge clk); #1;
    drive_nop(); mem_ack = 0; e_buserr = 0;
  endtask

  int base_s, base_r, base_b, base_m;

  initial begin
    rst = 1; drive_nop(); mem_ack = 0; mem_rdata = '0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst = 0;
    // Ack while idle is ignored.
    mem_ack = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("idle_ack_mmo_lit", mmo, 64'h0);

    base_s = stall_cnt;
    run_op(1, 0, 3'b011, 64'h10, 64'h1122334455667788, 0, 3);
    chk("t1_stall_cycles_lit", 64'(stall_cnt - base_s), 64'd4);
    chk("t1_addr_lit", 64'(last_addr), 64'd2);
    chk("t1_wstrb_lit", 64'(last_wstrb), 64'hFF);
    chk("t1_wdata_lit", last_wdata, 64'h1122334455667788);

    run_op(0, 1, 3'b000, 64'h13, 0, 64'h0000_0000_8000_0000, 1);
    chk("t2_lb_lit", mmo, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(0, 1, 3'b100, 64'h13, 0, 64'h0000_0000_8000_0000, 2);
    chk("t2_lbu_lit", mmo, 64'h80);

    run_op(1, 0, 3'b001, 64'h06, 64'hABCD, 0, 1);
    chk("t3_wstrb_lit", 64'(last_wstrb), 64'hC0);
    chk("t3_wdata_hi_lit", 64'(last_wdata[63:48]), 64'hABCD);

    run_op(0, 1, 3'b101, 64'h2A, 0, 64'hF00D_8001_2345_6789, 1);
    run_op(0, 1, 3'b001, 64'h2C, 0, 64'hF00D_8001_2345_6789, 2);
    chk("lh_lit", mmo, 64'hFFFF_FFFF_FFFF_8001);
    run_op(0, 1, 3'b110, 64'h34, 0, 64'hF00D_8001_2345_6789, 1);
    run_op(0, 1, 3'b011, 64'h30, 0, 64'h0123_4567_89AB_CDEF, 4);
    run_op(1, 0, 3'b000, 64'h0F, 64'h77, 0, 1);
    run_op(1, 0, 3'b010, 64'h44, 64'hDEAD_BEEF, 0, 2);
    // Store wins over load; mmo keeps the last load value.
    run_op(1, 1, 3'b010, 64'h48, 64'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    chk("st_ld_mmo_lit", mmo, 64'h0123_4567_89AB_CDEF);

    base_s = stall_cnt; base_r = req_cnt;
    run_op(1, 0, 3'b100, 64'h50, 64'h1, 0, 1);
    run_op(0, 1, 3'b111, 64'h50, 0, 0, 1);
    chk("illegal_stall_lit", 64'(stall_cnt - base_s), 64'd0);
    chk("illegal_req_lit", 64'(req_cnt - base_r), 64'd0);

    base_r = req_cnt; base_m = mis_cnt;
    run_op(0, 1, 3'b010, 64'h06, 0, 64'h89AB_CDEF_0123_4567, 1);
    if (TRAP) begin
      chk("t6_mis_pulse_lit", 64'(mis_cnt - base_m), 64'd1);
      chk("t6_no_req_lit", 64'(req_cnt - base_r), 64'd0);
      chk("t6_mmo_lit", mmo, 64'h0);
    end else begin
      chk("t6_mmo_lit", mmo, 64'hFFFF_FFFF_89AB_CDEF);
    end

    base_r = req_cnt; base_b = buserr_cnt;
    run_op(0, 1, 3'b010, 64'h20, 0, 0, 0);
    chk("t4_busy_cycles_lit", 64'(req_cnt - base_r), 64'(TO));
    chk("t4_buserr_pulse_lit", 64'(buserr_cnt - base_b), 64'd1);
    chk("t4_mmo_lit", mmo, 64'h0);

    run_op(0, 1, 3'b011, 64'h38, 0, 64'hCAFE_F00D_1234_5678, 1);

    // Reset while BUSY: abandoned request, later ack ignored.
    @(posedge clk); #1;
    mm2reg = 1; mfunc3 = 3'b010; mr = 64'h20;
    e_stall = 1; e_req = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      e_stall = 1; e_req = 1; e_we = 0; e_addr = 13'd4; e_wdata = '0; e_wstrb = '0;
    end
    @(posedge clk); #1;
    rst = 1; drive_nop();
    @(posedge clk); #1;
    rst = 0; mem_ack = 1; mem_rdata = 64'h1111_2222_3333_4444;
    e_stall = 0; e_req = 0; e_mmo = '0;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("t5_mmo_lit", mmo, 64'h0);
    chk("t5_req_lit", 64'(mem_req), 64'd0);
    @(posedge clk); #1;

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
